apb_mem_slave: RTL and testbench

//  Parametrised APB2 memory-mapped slave with a register-file backing store.
//  - Generalises the fixed 8-bit / 64-entry slave: configurable width and depth,

---
 rtl/apb_mem_slave.sv | 177 +++++++++++++++++
 tb/tb_apb_mem_slave.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
//   APB2 memory-mapped slave backed by a DEPTH x DATA_W register file.
//   The width, the depth and the number of access-phase wait states are all
//   configurable. PRDATA is registered and loaded on the setup edge of a read.
//
// Parameters
//   ADDR_W       PADDR width in bits
//   DATA_W       PWDATA / PRDATA width in bits
//   DEPTH        number of memory words (power of two, >= 2, <= 2**ADDR_W)
//   WAIT_CYCLES  wait states inserted in the access phase (0..15)
//
// Ports
//   PCLK     in   clock, rising edge
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   slave select
//   PENABLE  in   access-phase strobe
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   address; word index = PADDR[$clog2(DEPTH)-1:0]
//   PWDATA   in   write data
//   PRDATA   out  registered read data
//   PREADY   out  transfer complete
//   PSLVERR  out  transfer error, qualified by PREADY
//
// Configuration macro
//   APB_MEM_SLVERR_EN  defined: addresses >= DEPTH give PSLVERR, the write is
//                      suppressed and a read returns 0.
//                      undefined: PSLVERR is 0 and addresses wrap modulo DEPTH.
// -----------------------------------------------------------------------------
module apb_mem_slave #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    // ST_SETUP is entered straight after a completed transfer so that a
    // back-to-back setup phase is taken without an idle cycle. Both ST_IDLE
    // and ST_SETUP accept a setup phase (PSEL & !PENABLE) and perform the
    // setup work on that edge, which keeps the latency at 2 + WAIT_CYCLES.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              setup_s;
    logic              ready_s;
    logic              mem_we_s;
    logic              addr_err_s;
    logic [IDX_W-1:0]  addr_idx_s;

`ifdef APB_MEM_SLVERR_EN
    // Any set bit above the word index means the address is beyond DEPTH.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = IDX_W; i < ADDR_W; i++) begin
            hit = hit | addr[i];
        end
        return hit;
    endfunction

    assign addr_err_s = out_of_range(PADDR);
    assign PSLVERR    = ready_s & err_q;
`else
    assign addr_err_s = 1'b0;
    assign PSLVERR    = 1'b0;
`endif

    assign addr_idx_s = PADDR[IDX_W-1:0];
    assign setup_s    = ((state_q == ST_IDLE) || (state_q == ST_SETUP)) &&
                        PSEL && !PENABLE;
    // Decoded from registered state and the bus strobes only; PADDR is not
    // on this path.
    assign ready_s    = (state_q == ST_ACCESS) && PSEL && PENABLE &&
                        (cnt_q == 4'd0);

    assign PREADY = ready_s;
    assign PRDATA = rdata_q;

    // Next-state, latched-transfer and write-enable decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_SETUP: begin
                if (setup_s) begin
                    idx_d   = addr_idx_s;
                    write_d = PWRITE;
                    err_d   = addr_err_s;
                    cnt_d   = WAIT_LOAD;
                    if (!PWRITE) begin
                        rdata_d = addr_err_s ? {DATA_W{1'b0}} : mem_q[addr_idx_s];
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    // Aborted transfer: nothing is written, PRDATA is kept.
                    state_d = ST_IDLE;
                end else if (ready_s) begin
                    mem_we_s = write_q & ~err_q;
                    state_d  = ST_SETUP;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and read-data registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= {IDX_W{1'b0}};
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Backing store; deliberately not reset. The write enable is derived
    // from reset state, so a reset during ACCESS cancels a pending write.
    always_ff @(posedge PCLK) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= PWDATA;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave
//   Scoreboard bench for apb_mem_slave. Three instances share one APB bus and
//   each has its own PSEL: inst 0 has WAIT_CYCLES=0, inst 1 has 3 and inst 2
//   has 2. The stimulus pushes the expected response of each transfer into a
//   queue. A monitor pops that queue on every PREADY and checks PRDATA,
//   PSLVERR, the instance and the latency counted from the setup cycle.
// -----------------------------------------------------------------------------
module tb_apb_mem_slave;

`ifdef APB_MEM_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    logic            pclk = 1'b0;
    logic            rst_n;
    logic [2:0]      psel;
    logic            penable;
    logic            pwrite;
    logic [7:0]      paddr;
    logic [7:0]      pwdata;
    logic [2:0][7:0] prdata;
    logic [2:0]      pready;
    logic [2:0]      pslverr;

    typedef struct {
        int         inst;
        logic [7:0] rdata;
        logic       slverr;
        int         lat;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] last_rd [3];
    int         lat_cnt [3];
    int         n_cmp  = 0;
    int         n_fail = 0;

    always #5 pclk = ~pclk;

    apb_mem_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
        .PCLK(pclk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_mem_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(3)) u_w3 (
        .PCLK(pclk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb_mem_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
        .PCLK(pclk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A write must leave PRDATA at the value of the last read on that slave.
    task automatic push(input int inst, input bit wr, input logic [7:0] rd,
                        input logic err, input int lat);
        exp_t e;
        if (!wr) begin
            last_rd[inst] = rd;
        end
        e.inst   = inst;
        e.rdata  = last_rd[inst];
        e.slverr = err;
        e.lat    = lat;
        sb_q.push_back(e);
    endtask

    // Called at posedge+1; leaves the bus in the access phase at posedge+1
    // after the completion edge so the caller can chain a new setup.
    task automatic xfer(input int inst, input bit wr, input logic [7:0] addr,
                        input logic [7:0] data);
        int k;
        psel       = 3'b000;
        psel[inst] = 1'b1;
        penable    = 1'b0;
        pwrite     = wr;
        paddr      = addr;
        pwdata     = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (k = 0; k < 40; k++) begin
            @(negedge pclk);
            if (pready[inst]) break;
        end
        if (k == 40) check("timeout", 32'(pready[inst]), 32'd1);
        @(posedge pclk); #1;
    endtask

    task automatic idle();
        psel    = 3'b000;
        penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    // Monitor: count the latency from the setup cycle and check every PREADY.
    always @(negedge pclk) begin
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) lat_cnt[i] = 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (psel[i] && !penable)     lat_cnt[i] = 1;
                else if (psel[i] && penable) lat_cnt[i] = lat_cnt[i] + 1;
                else                         lat_cnt[i] = 0;
                if (pready[i]) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_pready", 32'(pready[i]), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("inst",    32'(i),          32'(e.inst));
                        check("prdata",  32'(prdata[i]),  32'(e.rdata));
                        check("pslverr", 32'(pslverr[i]), 32'(e.slverr));
                        check("latency", 32'(lat_cnt[i]), 32'(e.lat));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;

        // Reset state of all three slaves.
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        for (int i = 0; i < 3; i++) begin
            check("rst_pready",  32'(pready[i]),  32'd0);
            check("rst_prdata",  32'(prdata[i]),  32'd0);
            check("rst_pslverr", 32'(pslverr[i]), 32'd0);
        end
        @(posedge pclk); #1;
        rst_n = 1'b1;
        @(posedge pclk); #1;

        // Write then read, no wait states.
        push(0, 1'b1, 8'h00, 1'b0, 2);  xfer(0, 1'b1, 8'h10, 8'hA5);  idle();
        push(0, 1'b0, 8'hA5, 1'b0, 2);  xfer(0, 1'b0, 8'h10, 8'h00);  idle();

        // Back-to-back write then read, no idle cycle in between.
        push(0, 1'b1, 8'h00, 1'b0, 2);  xfer(0, 1'b1, 8'h02, 8'h11);
        push(0, 1'b0, 8'h11, 1'b0, 2);  xfer(0, 1'b0, 8'h02, 8'h00);  idle();

        // Out-of-range write 0x77 @0x50 (index 0x10 if it wraps).
        push(0, 1'b1, 8'h00, SLV, 2);   xfer(0, 1'b1, 8'h50, 8'h77);  idle();
        push(0, 1'b0, SLV ? 8'hA5 : 8'h77, 1'b0, 2);
        xfer(0, 1'b0, 8'h10, 8'h00);  idle();
        push(0, 1'b0, SLV ? 8'h00 : 8'h77, SLV, 2);
        xfer(0, 1'b0, 8'h50, 8'h00);  idle();

        // Three wait states: PREADY only on the 4th access cycle.
        push(1, 1'b1, 8'h00, 1'b0, 5);  xfer(1, 1'b1, 8'h01, 8'h3C);  idle();
        push(1, 1'b0, 8'h3C, 1'b0, 5);  xfer(1, 1'b0, 8'h01, 8'h00);  idle();

        // Reset in the middle of a write's access phase.
        push(1, 1'b1, 8'h00, 1'b0, 5);  xfer(1, 1'b1, 8'h07, 8'h42);  idle();
        push(1, 1'b0, 8'h42, 1'b0, 5);  xfer(1, 1'b0, 8'h07, 8'h00);  idle();
        psel    = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h07;
        pwdata  = 8'h99;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        rst_n   = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        #1;
        check("midrst_pready", 32'(pready[1]), 32'd0);
        check("midrst_prdata", 32'(prdata[1]), 32'd0);
        @(posedge pclk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
        @(posedge pclk); #1;
        push(1, 1'b0, 8'h42, 1'b0, 5);  xfer(1, 1'b0, 8'h07, 8'h00);  idle();

        // Aborted write with two wait states.
        push(2, 1'b1, 8'h00, 1'b0, 4);  xfer(2, 1'b1, 8'h05, 8'h5A);  idle();
        push(2, 1'b0, 8'h5A, 1'b0, 4);  xfer(2, 1'b0, 8'h05, 8'h00);  idle();
        psel    = 3'b100;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h05;
        pwdata  = 8'hFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        idle();
        idle();
        check("abort_prdata", 32'(prdata[2]), 32'h5A);
        push(2, 1'b0, 8'h5A, 1'b0, 4);  xfer(2, 1'b0, 8'h05, 8'h00);  idle();

        repeat (3) @(posedge pclk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
